// File: rtl/conv_pkg.sv
// Shared constants and capture FSM encoding for the conv pipeline.
package conv_pkg;

    localparam int unsigned CONV_PXL_W = 8;
    localparam int unsigned CONV_IMG_W = 220;
    localparam int unsigned CONV_IMG_H = 218;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCapture = 2'd1,
        StDone    = 2'd2,
        StReadout = 2'd3
    } cap_state_e;

endpackage

// File: rtl/frame_ram.sv
// Single-clock frame store: one write port, one synchronous read port with resettable output.
module frame_ram #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // Array has no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/frame_capture.sv
// Captures one IMG_W x IMG_H frame from the conv stream, then streams it back on request.
// Define CAPTURE_CHECKSUM_EN to add a 16-bit running sum of written pixels.
module frame_capture
    import conv_pkg::*;
#(
    parameter int unsigned IMG_W = CONV_IMG_W,
    parameter int unsigned IMG_H = CONV_IMG_H,
    parameter int unsigned PXL_W = CONV_PXL_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PXL_W-1:0] pxl_in,
    input  logic             pxl_valid,
    input  logic             frame_start,
    input  logic             rd_en,
    output logic [PXL_W-1:0] rd_data,
    output logic             rd_valid,
    output logic [15:0]      col,
    output logic [15:0]      row,
    output logic             frame_done,
    output logic             overflow,
`ifdef CAPTURE_CHECKSUM_EN
    output logic [15:0]      checksum,
`endif
    output logic             busy
);

    localparam int unsigned   DEPTH     = IMG_W * IMG_H;
    localparam int unsigned   AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [15:0]   LAST_COL  = 16'(IMG_W - 1);

    cap_state_e    r_state;
    logic [AW-1:0] r_wr_addr;
    logic [AW-1:0] r_rd_addr;
    logic [15:0]   r_col;
    logic [15:0]   r_row;
    logic          r_frame_done;
    logic          r_overflow;
    logic          r_rd_valid;
    logic          r_busy;

    logic          w_wr_en;
    logic [AW-1:0] w_wr_addr;
    logic          w_rd_en;

    // A restart in CAPTURE writes the coincident pixel to address 0.
    assign w_wr_en   = (r_state == StCapture) && pxl_valid;
    assign w_wr_addr = frame_start ? '0 : r_wr_addr;
    assign w_rd_en   = rd_en && ((r_state == StDone) || (r_state == StReadout));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= StIdle;
            r_wr_addr    <= '0;
            r_rd_addr    <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_rd_valid   <= 1'b0;
            if (pxl_valid && (r_state != StCapture)) begin
                r_overflow <= 1'b1;
            end
            case (r_state)
                StIdle: begin
                    if (frame_start) begin
                        r_state   <= StCapture;
                        r_wr_addr <= '0;
                        r_col     <= '0;
                        r_row     <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                StCapture: begin
                    if (frame_start) begin
                        r_row     <= '0;
                        r_wr_addr <= pxl_valid ? AW'(1) : '0;
                        r_col     <= pxl_valid ? 16'd1 : 16'd0;
                    end else if (pxl_valid) begin
                        if (r_col == LAST_COL) begin
                            r_col <= '0;
                            r_row <= r_row + 16'd1;
                        end else begin
                            r_col <= r_col + 16'd1;
                        end
                        if (r_wr_addr == LAST_ADDR) begin
                            r_state      <= StDone;
                            r_frame_done <= 1'b1;
                            r_busy       <= 1'b0;
                            r_wr_addr    <= '0;
                        end else begin
                            r_wr_addr <= r_wr_addr + AW'(1);
                        end
                    end
                end
                // r_rd_addr is always 0 on entry to DONE, so the first read hits address 0.
                StDone, StReadout: begin
                    if (rd_en) begin
                        r_rd_valid <= 1'b1;
                        if (r_rd_addr == LAST_ADDR) begin
                            r_state   <= StIdle;
                            r_busy    <= 1'b0;
                            r_rd_addr <= '0;
                        end else begin
                            r_state   <= StReadout;
                            r_busy    <= 1'b1;
                            r_rd_addr <= r_rd_addr + AW'(1);
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

`ifdef CAPTURE_CHECKSUM_EN
    logic [15:0] r_checksum;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_checksum <= '0;
        end else if (frame_start && ((r_state == StIdle) || (r_state == StCapture))) begin
            r_checksum <= w_wr_en ? 16'(pxl_in) : 16'd0;
        end else if (w_wr_en) begin
            r_checksum <= r_checksum + 16'(pxl_in);
        end
    end

    assign checksum = r_checksum;
`endif

    frame_ram #(
        .WIDTH (PXL_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_frame_ram (
        .clk       (clk),
        .i_rst_n   (reset),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (pxl_in),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_rd_addr),
        .o_rd_data (rd_data)
    );

    assign rd_valid   = r_rd_valid;
    assign col        = r_col;
    assign row        = r_row;
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;
    assign busy       = r_busy;

endmodule

// File: tb/tb_frame_capture.sv
// Directed self-checking bench for frame_capture on a reduced 40x30 frame.
module tb_frame_capture;

    localparam int unsigned W     = 40;
    localparam int unsigned H     = 30;
    localparam int unsigned DEPTH = W * H;
    localparam int unsigned PW    = 8;

    logic          clk;
    logic          reset;
    logic [PW-1:0] pxl_in;
    logic          pxl_valid;
    logic          frame_start;
    logic          rd_en;
    logic [PW-1:0] rd_data;
    logic          rd_valid;
    logic [15:0]   col;
    logic [15:0]   row;
    logic          frame_done;
    logic          overflow;
    logic          busy;
`ifdef CAPTURE_CHECKSUM_EN
    logic [15:0]   checksum;
`endif

    frame_capture #(
        .IMG_W (W),
        .IMG_H (H),
        .PXL_W (PW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pxl_in      (pxl_in),
        .pxl_valid   (pxl_valid),
        .frame_start (frame_start),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .col         (col),
        .row         (row),
        .frame_done  (frame_done),
        .overflow    (overflow),
`ifdef CAPTURE_CHECKSUM_EN
        .checksum    (checksum),
`endif
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        fs;
        logic        pv;
        logic [7:0]  px;
        logic        re;
        logic [15:0] col;
        logic [15:0] row;
        logic        busy;
        logic        rdv;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int issued;
        logic req;

        vecs[0] = '{fs: 0, pv: 0, px: 8'h00, re: 1, col: 0, row: 0, busy: 0, rdv: 0};
        vecs[1] = '{fs: 1, pv: 0, px: 8'h00, re: 0, col: 0, row: 0, busy: 1, rdv: 0};
        vecs[2] = '{fs: 0, pv: 1, px: 8'h11, re: 1, col: 1, row: 0, busy: 1, rdv: 0};
        vecs[3] = '{fs: 0, pv: 0, px: 8'h00, re: 0, col: 1, row: 0, busy: 1, rdv: 0};
        vecs[4] = '{fs: 0, pv: 1, px: 8'h22, re: 0, col: 2, row: 0, busy: 1, rdv: 0};
        vecs[5] = '{fs: 0, pv: 0, px: 8'h00, re: 0, col: 2, row: 0, busy: 1, rdv: 0};
        vecs[6] = '{fs: 1, pv: 1, px: 8'h33, re: 0, col: 1, row: 0, busy: 1, rdv: 0};
        vecs[7] = '{fs: 0, pv: 0, px: 8'h00, re: 1, col: 1, row: 0, busy: 1, rdv: 0};
        vecs[8] = '{fs: 1, pv: 0, px: 8'h00, re: 0, col: 0, row: 0, busy: 1, rdv: 0};

        reset       = 1'b0;
        pxl_in      = '0;
        pxl_valid   = 1'b0;
        frame_start = 1'b0;
        rd_en       = 1'b0;
        repeat (3) step();
        check("reset col", col, 0);
        check("reset row", row, 0);
        check("reset busy", busy, 0);
        check("reset rd_valid", rd_valid, 0);
        check("reset rd_data", rd_data, 0);
        check("reset frame_done", frame_done, 0);
        check("reset overflow", overflow, 0);
`ifdef CAPTURE_CHECKSUM_EN
        check("reset checksum", checksum, 0);
`endif
        reset = 1'b1;
        step();

        // Idle rd_en, start, gapped 1,0,1,0 input, restarts with and without a pixel.
        for (int i = 0; i < 9; i++) begin
            frame_start = vecs[i].fs;
            pxl_valid   = vecs[i].pv;
            pxl_in      = vecs[i].px;
            rd_en       = vecs[i].re;
            step();
            check($sformatf("vec%0d col", i), col, vecs[i].col);
            check($sformatf("vec%0d row", i), row, vecs[i].row);
            check($sformatf("vec%0d busy", i), busy, vecs[i].busy);
            check($sformatf("vec%0d rd_valid", i), rd_valid, vecs[i].rdv);
            check($sformatf("vec%0d frame_done", i), frame_done, 0);
        end
        frame_start = 1'b0;
        rd_en       = 1'b0;

        // Full frame, pixel value = address mod 256.
        for (int a = 0; a < int'(DEPTH); a++) begin
            pxl_valid = 1'b1;
            pxl_in    = 8'(a);
            step();
            check("frame col", col, (a + 1) % W);
            check("frame row", row, (a + 1) / W);
            check("frame frame_done", frame_done, (a == int'(DEPTH) - 1) ? 1 : 0);
            check("frame busy", busy, (a == int'(DEPTH) - 1) ? 0 : 1);
        end
        pxl_valid = 1'b0;
        step();
        check("frame_done single pulse", frame_done, 0);
        check("done col", col, 0);
        check("done row", row, H);
        check("no overflow after frame", overflow, 0);

        // Pixel and frame_start in DONE: pixel dropped, start ignored.
        pxl_valid   = 1'b1;
        pxl_in      = 8'hEE;
        frame_start = 1'b1;
        step();
        pxl_valid   = 1'b0;
        frame_start = 1'b0;
        check("overflow in DONE", overflow, 1);
        check("frame_start ignored in DONE", busy, 0);
        check("col held in DONE", col, 0);

        // Readout with rd_en dropped every 7th cycle.
        issued = 0;
        for (int c = 0; c < 2 * int'(DEPTH) && issued < int'(DEPTH); c++) begin
            req   = (c % 7 != 3);
            rd_en = req;
            step();
            check("readout rd_valid", rd_valid, req);
            if (req) begin
                check("readout rd_data", rd_data, issued % 256);
                issued++;
            end
            check("readout busy", busy, (issued > 0 && issued < int'(DEPTH)) ? 1 : 0);
        end
        check("readout beat count", issued, DEPTH);
        rd_en = 1'b1;
        step();
        check("rd_en ignored in IDLE", rd_valid, 0);
        check("idle busy after readout", busy, 0);
        rd_en = 1'b0;
        check("overflow sticky after readout", overflow, 1);

        // Async reset in the middle of a capture.
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            pxl_valid = 1'b1;
            pxl_in    = 8'(i);
            step();
        end
        pxl_valid = 1'b0;
        check("pre-reset col", col, 1000 % W);
        check("pre-reset row", row, 1000 / W);
        check("pre-reset busy", busy, 1);
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check("async reset busy", busy, 0);
        check("async reset col", col, 0);
        check("async reset row", row, 0);
        check("async reset overflow", overflow, 0);
        check("async reset rd_valid", rd_valid, 0);
        step();
        reset = 1'b1;
        step();
        check("idle after reset", busy, 0);

`ifdef CAPTURE_CHECKSUM_EN
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        pxl_valid   = 1'b1;
        pxl_in      = 8'hFF;
        step();
        pxl_in = 8'h01;
        step();
        pxl_in = 8'h10;
        step();
        pxl_valid = 1'b0;
        step();
        check("checksum", checksum, 16'h0110);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_capture.md
FRAME_CAPTURE -- requirements
Module: frame_capture

Interface
REQ-001 SHALL have parameter IMG_W, default 220, output pixels per row.
REQ-002 SHALL have parameter IMG_H, default 218, output rows per frame.
REQ-003 SHALL have parameter PXL_W, default 8, pixel width.
REQ-004 SHALL have port clk  input  1  single clock, rising-edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port pxl_in  input  PXL_W  pixel from the conv_31 pxl_out stream.
REQ-007 SHALL have port pxl_valid  input  1  pxl_in qualifier, driven by the conv_31 valid output.
REQ-008 SHALL have port frame_start  input  1  one-cycle pulse that arms capture.
REQ-009 SHALL have port rd_en  input  1  readout request, one pixel per cycle.
REQ-010 SHALL have port rd_data  output  PXL_W  stored pixel.
REQ-011 SHALL have port rd_valid  output  1  rd_data qualifier.
REQ-012 SHALL have port col  output  16  current capture column.
REQ-013 SHALL have port row  output  16  current capture row.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse when the last pixel is written.
REQ-015 SHALL have port overflow  output  1  sticky flag for a dropped pixel.
REQ-016 SHALL have port busy  output  1  high in CAPTURE or READOUT.

Function
REQ-017 SHALL implement the states IDLE, CAPTURE, DONE and READOUT.
REQ-018 SHALL move IDLE->CAPTURE on frame_start, clearing wr_addr, col and row.
REQ-019 SHALL, in CAPTURE with pxl_valid=1, write pxl_in to mem[wr_addr] and then increment wr_addr and col.
REQ-020 SHALL wrap col from IMG_W-1 to 0 and increment row on that wrap.
REQ-021 SHALL, on the write to address IMG_W*IMG_H-1, go to DONE and pulse frame_done high for exactly one cycle.
REQ-022 SHALL hold all counters in CAPTURE while pxl_valid=0, with no write.
REQ-023 SHALL restart capture from address 0 when frame_start occurs in CAPTURE; a pxl_valid in that same cycle is written to address 0.
REQ-024 SHALL move DONE->READOUT on rd_en=1; that same cycle issues the read of address 0.
REQ-025 SHALL, in READOUT with rd_en=1, read mem[rd_addr] and increment rd_addr; rd_data and rd_valid follow one cycle later (latency 1).
REQ-026 SHALL, in READOUT with rd_en=0, issue no read and drive rd_valid=0 the next cycle.
REQ-027 SHALL return READOUT->IDLE after the read of address IMG_W*IMG_H-1.
REQ-028 SHALL, on pxl_valid=1 in IDLE, DONE or READOUT, drop the pixel and set overflow; only reset clears overflow.
REQ-029 SHALL ignore frame_start in DONE and READOUT.
REQ-030 SHALL ignore rd_en in IDLE and CAPTURE; rd_valid stays 0 there.

Reset
REQ-031 SHALL, while reset=0, force state=IDLE and clear wr_addr, rd_addr, col, row, rd_data, rd_valid, frame_done, overflow and busy to 0, regardless of clk.
REQ-032 SHALL abandon any capture or readout in progress on reset, leaving memory contents undefined.

Configuration
REQ-033 SHALL, when CAPTURE_CHECKSUM_EN is defined, add output checksum (16 bits, reset 0).
REQ-034 SHALL, with CAPTURE_CHECKSUM_EN, clear checksum on the IDLE->CAPTURE transition and add each written pixel, zero-extended, modulo 2^16.
REQ-035 SHALL, without CAPTURE_CHECKSUM_EN, have no checksum port and no checksum logic.

Structure
REQ-036 SHALL import PXL_W, the IMG_W and IMG_H defaults, and the state encoding from the shared package conv_pkg.
REQ-037 SHALL place storage in sub-module frame_ram: single clock, one write port, one synchronous read port, depth IMG_W*IMG_H.

Verification
REQ-038 SHALL test a full frame: frame_start, then 47960 valid pixels of value addr mod 256 -> frame_done pulses once at the last write, col=0, row=218 after the wrap.
REQ-039 SHALL test gapped input: pxl_valid toggling 1,0,1,0 over 4 pixels -> wr_addr advances by exactly 2, col=2.
REQ-040 SHALL test readout: rd_en held high after DONE -> 47960 rd_valid beats, data equal to addr mod 256 in order, then IDLE.
REQ-041 SHALL test overflow: pxl_valid=1 in DONE -> overflow=1, memory unchanged, overflow still 1 after readout.
REQ-042 SHALL test async reset: reset=0 at pixel 1000 of capture -> state=IDLE, col=row=0, busy=0 with no clock edge.
REQ-043 SHALL test checksum with CAPTURE_CHECKSUM_EN: 3 pixels 0xFF, 0x01, 0x10 -> checksum=0x0110.
